// File: rtl/flicky_sound_latch_pkg.sv
// Shared definitions for the sound-command latch and the sound-CPU top.
package flicky_sound_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } nmi_state_t;

  localparam int unsigned IRQ_DIV_DEFAULT = 192000;
  localparam int unsigned NMI_CNT_W       = 8;
  localparam int unsigned CMD_W           = 8;

  // Counter width for a modulus, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// Command FIFO with a registered head byte that holds the last popped value
// while empty.
module snd_cmd_fifo
  import flicky_sound_latch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wr_data,
  output logic [CMD_W-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic [CMD_W-1:0] head_n;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so push-while-full-with-pop is accepted.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    count_n  = count + CW'(do_push) - CW'(do_pop);
    rd_ptr_n = rd_ptr + AW'(do_pop);
    head_n   = head;
    if (count_n != '0) begin
      if (do_push && (rd_ptr_n == wr_ptr)) head_n = wr_data;
      else                                 head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      head   <= head_n;
      empty  <= (count_n == '0);
      full   <= (count_n == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/flicky_sound_latch.sv
// Main-CPU to sound-CPU command latch: command FIFO, per-command NMI pulse
// and periodic maskable interrupt.
module flicky_sound_latch
  import flicky_sound_latch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NMI_LEN    = 16,
  parameter int unsigned IRQ_DIV    = IRQ_DIV_DEFAULT
) (
  input  logic             CLK48M,
  input  logic             RESETn,
  input  logic             SNDRQ,
  input  logic [CMD_W-1:0] CPUDO,
  input  logic             SRD,
  input  logic             SINTACK,
  output logic [CMD_W-1:0] SDO,
  output logic             SNMI,
  output logic             SINT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IRQ_W = cnt_width(IRQ_DIV);

  logic sndrq_q, srd_q, ack_q;
  logic push_c, pop_c, ackedge_c;

  logic [CW-1:0] fifo_count;

  nmi_state_t           state_q, state_n;
  logic [NMI_CNT_W-1:0] nmi_cnt_q, nmi_cnt_n;
  logic                 snmi_n;

  logic [IRQ_W-1:0] irq_cnt_q;
  logic             irq_wrap_c;

  // Edge detectors: one push per SNDRQ rise, one pop per SRD fall.
  always_comb begin
    push_c    = SNDRQ & ~sndrq_q;
    pop_c     = ~SRD & srd_q & ~EMPTY;
    ackedge_c = SINTACK & ~ack_q;
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      sndrq_q <= 1'b0;
      srd_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      sndrq_q <= SNDRQ;
      srd_q   <= SRD;
      ack_q   <= SINTACK;
    end
  end

  snd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK48M),
    .rst_n   (RESETn),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (CPUDO),
    .head    (SDO),
    .count   (fifo_count),
    .empty   (EMPTY),
    .full    (FULL)
  );

  // Sticky overflow: a push that found no room and had no pop to make one.
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) OVF <= 1'b0;
    else if (push_c && !pop_c && (fifo_count == CW'(FIFO_DEPTH))) OVF <= 1'b1;
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      nmi_cnt_q <= '0;
      SNMI      <= 1'b0;
    end else begin
      state_q   <= state_n;
      nmi_cnt_q <= nmi_cnt_n;
      SNMI      <= snmi_n;
    end
  end

  // One fixed-length NMI per command; re-arms only after the sound CPU reads.
  always_comb begin
    state_n   = state_q;
    nmi_cnt_n = nmi_cnt_q;
    snmi_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!EMPTY) begin
          state_n   = PULSE;
          nmi_cnt_n = NMI_CNT_W'(NMI_LEN - 1);
          snmi_n    = 1'b1;
        end
      end
      PULSE: begin
        if (nmi_cnt_q == '0) begin
          state_n = WAIT;
        end else begin
          nmi_cnt_n = nmi_cnt_q - NMI_CNT_W'(1);
          snmi_n    = 1'b1;
        end
      end
      WAIT: begin
        if (pop_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign irq_wrap_c = (irq_cnt_q == IRQ_W'(IRQ_DIV - 1));

  // Free-running divider; a wrap outranks a simultaneous acknowledge.
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      irq_cnt_q <= '0;
      SINT      <= 1'b0;
    end else begin
      irq_cnt_q <= irq_wrap_c ? '0 : irq_cnt_q + IRQ_W'(1);
      if (irq_wrap_c)     SINT <= 1'b1;
      else if (ackedge_c) SINT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flicky_sound_latch.sv
// Directed bench for flicky_sound_latch with a short IRQ period.
module tb_flicky_sound_latch;

  logic       clk = 1'b0;
  logic       RESETn;
  logic       SNDRQ;
  logic [7:0] CPUDO;
  logic       SRD;
  logic       SINTACK;
  logic [7:0] SDO;
  logic       SNMI, SINT, EMPTY, FULL, OVF;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nmi_rises = 0;
  logic snmi_prev = 1'b0;

  always #5 clk = ~clk;

  flicky_sound_latch #(
    .FIFO_DEPTH (4),
    .NMI_LEN    (16),
    .IRQ_DIV    (10)
  ) dut (
    .CLK48M  (clk),
    .RESETn  (RESETn),
    .SNDRQ   (SNDRQ),
    .CPUDO   (CPUDO),
    .SRD     (SRD),
    .SINTACK (SINTACK),
    .SDO     (SDO),
    .SNMI    (SNMI),
    .SINT    (SINT),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .OVF     (OVF)
  );

  always @(negedge clk) begin
    if (SNMI && !snmi_prev) nmi_rises++;
    snmi_prev = SNMI;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    SNDRQ = 1'b1;
    CPUDO = d;
    tick(3);
    SNDRQ = 1'b0;
    tick(3);
  endtask

  task automatic do_read();
    SRD = 1'b1;
    tick(2);
    SRD = 1'b0;
    tick(1);
  endtask

  initial begin
    int hi;
    int first;
    int base;
    logic [7:0] exp_q [3];

    RESETn = 1'b0; SNDRQ = 1'b0; CPUDO = 8'h00; SRD = 1'b0; SINTACK = 1'b0;
    tick(2);
    check("rst_sdo",   32'(SDO),   32'h00);
    check("rst_snmi",  32'(SNMI),  32'h0);
    check("rst_sint",  32'(SINT),  32'h0);
    check("rst_empty", 32'(EMPTY), 32'h1);
    check("rst_full",  32'(FULL),  32'h0);
    check("rst_ovf",   32'(OVF),   32'h0);
    RESETn = 1'b1;
    cyc = 0;

    // Periodic IRQ with a 10-cycle divider
    tick(9);  check("sint_c9", 32'(SINT), 32'h0);
    tick(1);  check("sint_c10", 32'(SINT), 32'h1);
    tick(3);  SINTACK = 1'b1;
    tick(1);  check("sint_ack_c14", 32'(SINT), 32'h0);
    tick(1);  SINTACK = 1'b0;
    tick(4);  check("sint_c19", 32'(SINT), 32'h0);
    tick(1);  check("sint_c20", 32'(SINT), 32'h1);
    tick(1);  SINTACK = 1'b1;
    tick(1);  check("sint_ack_c22", 32'(SINT), 32'h0);
    SINTACK = 1'b0;
    tick(7);  check("sint_c29", 32'(SINT), 32'h0);
    SINTACK = 1'b1;
    tick(1);  check("sint_wrap_wins", 32'(SINT), 32'h1);
    SINTACK = 1'b0;
    tick(1);  check("sint_c31", 32'(SINT), 32'h1);

    // Single long write of 0x5A
    SNDRQ = 1'b1; CPUDO = 8'h5A;
    hi = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 1) begin
        check("w1_sdo",   32'(SDO),   32'h5A);
        check("w1_empty", 32'(EMPTY), 32'h0);
        check("w1_snmi_e", 32'(SNMI), 32'h0);
      end
      if (SNMI) begin
        hi++;
        if (first == 0) first = i;
      end
    end
    SNDRQ = 1'b0;
    check("w1_nmi_len",   32'(hi),    32'd16);
    check("w1_nmi_start", 32'(first), 32'd2);
    tick(2);
    do_read();
    check("w1_rd_empty", 32'(EMPTY), 32'h1);
    check("w1_rd_sdo",   32'(SDO),   32'h5A);
    tick(5);
    check("w1_no_refire", 32'(SNMI), 32'h0);

    // Fill past capacity, then drain in order
    base = nmi_rises;
    for (int k = 1; k <= 4; k++) do_write(8'(k));
    check("fill_full4", 32'(FULL), 32'h1);
    check("fill_ovf4",  32'(OVF),  32'h0);
    do_write(8'h05);
    check("fill_full5", 32'(FULL), 32'h1);
    check("fill_ovf5",  32'(OVF),  32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick(20);
      check($sformatf("drain_sdo%0d", k), 32'(SDO), 32'(k));
      do_read();
    end
    check("drain_empty", 32'(EMPTY), 32'h1);
    check("drain_sdo_hold", 32'(SDO), 32'h04);
    tick(20);
    check("drain_nmi_count", 32'(nmi_rises - base), 32'd4);

    // Simultaneous push and pop with three queued
    do_write(8'hA1); do_write(8'hA2); do_write(8'hA3);
    tick(20);
    SRD = 1'b1;
    tick(2);
    SRD = 1'b0; SNDRQ = 1'b1; CPUDO = 8'hA4;
    tick(1);
    check("sim_sdo",   32'(SDO),   32'hA2);
    check("sim_full",  32'(FULL),  32'h0);
    check("sim_empty", 32'(EMPTY), 32'h0);
    SNDRQ = 1'b0;
    exp_q[0] = 8'hA2; exp_q[1] = 8'hA3; exp_q[2] = 8'hA4;
    for (int k = 0; k < 3; k++) begin
      tick(20);
      check($sformatf("sim_drain%0d", k), 32'(SDO), 32'(exp_q[k]));
      do_read();
    end
    check("sim_drain_empty", 32'(EMPTY), 32'h1);

    // Asynchronous reset during an NMI pulse with two queued
    do_write(8'hB1); do_write(8'hB2);
    check("ar_pre_snmi",  32'(SNMI),  32'h1);
    check("ar_pre_empty", 32'(EMPTY), 32'h0);
    #2 RESETn = 1'b0;
    #1;
    check("ar_snmi",  32'(SNMI),  32'h0);
    check("ar_empty", 32'(EMPTY), 32'h1);
    check("ar_ovf",   32'(OVF),   32'h0);
    check("ar_sdo",   32'(SDO),   32'h00);
    check("ar_full",  32'(FULL),  32'h0);
    check("ar_sint",  32'(SINT),  32'h0);
    @(negedge clk);
    RESETn = 1'b1;
    cyc = 0;

    // Push into a full FIFO alongside a pop is accepted
    for (int k = 1; k <= 4; k++) do_write(8'hC0 + 8'(k));
    check("fp_full", 32'(FULL), 32'h1);
    SRD = 1'b1;
    tick(2);
    SRD = 1'b0; SNDRQ = 1'b1; CPUDO = 8'hC5;
    tick(1);
    check("fp_ovf",  32'(OVF),  32'h0);
    check("fp_full_after", 32'(FULL), 32'h1);
    check("fp_sdo",  32'(SDO),  32'hC2);
    SNDRQ = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
